// File: rtl/emem_read_arbiter.sv
// emem_read_arbiter: two-client burst read arbiter in front of a 1-cycle-latency memory.
// Define EMEM_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority (client 0 wins).
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif

module emem_read_arbiter #(
   parameter int REG_SIZE = `REG_SIZE,
   parameter int MEM_SIZE = `MEM_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                c0_req,
   input  logic [REG_SIZE-1:0] c0_addr,
   input  logic [7:0]          c0_len,
   output logic                c0_gnt,
   output logic                c0_rvalid,
   output logic [REG_SIZE-1:0] c0_rdata,
   output logic                c0_done,
   input  logic                c1_req,
   input  logic [REG_SIZE-1:0] c1_addr,
   input  logic [7:0]          c1_len,
   output logic                c1_gnt,
   output logic                c1_rvalid,
   output logic [REG_SIZE-1:0] c1_rdata,
   output logic                c1_done,
   output logic [REG_SIZE-1:0] mem_address,
   input  logic [REG_SIZE-1:0] mem_data_out,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(MEM_SIZE - 1);

   state_t              state_q, state_d;
   logic [REG_SIZE-1:0] addr_q, addr_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic                gnt_q, gnt_d;
   logic                rvalid_q, rvalid_d;
   logic                done_q, done_d;
   logic                win;
   logic [7:0]          len_sel;

`ifdef EMEM_ARB_RR_EN
   logic prio_q, prio_d;

   // prio_q names the client that wins the next tie
   always_comb begin
      win = !c0_req;
      if (c0_req && c1_req) win = prio_q;
   end
`else
   always_comb win = !c0_req;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      gnt_d    = 1'b0;
      rvalid_d = 1'b0;
      done_d   = 1'b0;
      len_sel  = win ? c1_len : c0_len;
`ifdef EMEM_ARB_RR_EN
      prio_d   = prio_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (c0_req || c1_req) begin
               state_d = READ;
               owner_d = win;
               gnt_d   = 1'b1;
               addr_d  = win ? c1_addr : c0_addr;
               // cnt holds words remaining after the one on the bus
               cnt_d   = (len_sel == 8'd0) ? 8'd0 : len_sel - 8'd1;
`ifdef EMEM_ARB_RR_EN
               prio_d  = !win;
`endif
            end
         end
         READ: begin
            rvalid_d = 1'b1;
            if (cnt_q == 8'd0) begin
               done_d  = 1'b1;
               state_d = DRAIN;
            end else begin
               cnt_d  = cnt_q - 8'd1;
               addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            end
         end
         DRAIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         cnt_q    <= 8'd0;
         owner_q  <= 1'b0;
         gnt_q    <= 1'b0;
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         done_q   <= done_d;
      end
   end

`ifdef EMEM_ARB_RR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prio_q <= 1'b0;
      else      prio_q <= prio_d;
   end
`endif

   assign c0_gnt      = gnt_q & !owner_q;
   assign c1_gnt      = gnt_q & owner_q;
   assign c0_rvalid   = rvalid_q & !owner_q;
   assign c1_rvalid   = rvalid_q & owner_q;
   assign c0_done     = done_q & !owner_q;
   assign c1_done     = done_q & owner_q;
   assign c0_rdata    = c0_rvalid ? mem_data_out : '0;
   assign c1_rdata    = c1_rvalid ? mem_data_out : '0;
   assign mem_address = addr_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_emem_read_arbiter.sv
// Bench for emem_read_arbiter: burst vectors from a table, read words checked
// against a scoreboard fed from a behavioural memory model.
module tb_emem_read_arbiter;

   localparam int RS = 32;
   localparam int MS = 64;
`ifdef EMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          c0_req, c1_req;
   logic [RS-1:0] c0_addr, c1_addr;
   logic [7:0]    c0_len, c1_len;
   logic          c0_gnt, c0_rvalid, c0_done;
   logic          c1_gnt, c1_rvalid, c1_done;
   logic [RS-1:0] c0_rdata, c1_rdata;
   logic [RS-1:0] mem_address;
   logic [RS-1:0] mem_data_out = '0;
   logic          busy;

   emem_read_arbiter #(.REG_SIZE(RS), .MEM_SIZE(MS)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_addr(c0_addr), .c0_len(c0_len),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata), .c0_done(c0_done),
      .c1_req(c1_req), .c1_addr(c1_addr), .c1_len(c1_len),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata), .c1_done(c1_done),
      .mem_address(mem_address), .mem_data_out(mem_data_out), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mfun(input logic [31:0] a);
      return a ^ 32'h5A00_0000;
   endfunction

   always @(posedge clk) mem_data_out <= mfun(mem_address);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          cl;
      logic [31:0] data;
      bit          last;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      bit          r0, r1;
      logic [31:0] a0, a1;
      logic [7:0]  l0, l1;
      bit          w;
      bit          keep;
   } vec_t;

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %h, required %h", n, cyc, act, exp);
      end
   endtask

   function automatic void push_burst(input bit cl, input logic [31:0] a, input logic [7:0] l,
                                      input int s, output int nx, output logic [31:0] la);
      int n;
      n = (l == 8'd0) ? 1 : int'(l);
      la = a;
      for (int i = 0; i < n; i++) begin
         sbq.push_back('{cl: cl, data: mfun(a), last: (i == n - 1), cyc: s + 2 + i});
         la = a;
         a = (a == 32'(MS - 1)) ? 32'd0 : a + 32'd1;
      end
      nx = s + 2 + n;
   endfunction

   task automatic mon_one(input int c, input logic rv, input logic dn,
                          input logic [31:0] rd, input logic [31:0] od);
      exp_t e;
      if (rv && sbq.size() == 0) begin
         nvec++; nerr++;
         $display("FAIL spurious_rvalid c%0d at cycle %0d: got rvalid 1, required 0", c, cyc);
      end else if (rv) begin
         e = sbq.pop_front();
         check("rv_owner", 32'(c), 32'(e.cl));
         check("rv_data", rd, e.data);
         check("rv_cycle", 32'(cyc), 32'(e.cyc));
         check("rv_done", 32'(dn), 32'(e.last));
         check("nonowner_rdata", od, 32'd0);
      end else if (dn) begin
         nvec++; nerr++;
         $display("FAIL done_without_rvalid c%0d at cycle %0d: got done 1, required 0", c, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon_one(0, c0_rvalid, c0_done, c0_rdata, c1_rdata);
         mon_one(1, c1_rvalid, c1_done, c1_rdata, c0_rdata);
      end
   end

   task automatic run_vec(input vec_t v);
      int          start, nxt, fin;
      logic [31:0] la, wa, oa;
      logic [7:0]  wl, ol;
      bit          two;
      @(negedge clk);
      c0_req = v.r0; c0_addr = v.a0; c0_len = v.l0;
      c1_req = v.r1; c1_addr = v.a1; c1_len = v.l1;
      start = cyc;
      two = v.r0 && v.r1 && v.keep;
      wa = v.w ? v.a1 : v.a0;
      wl = v.w ? v.l1 : v.l0;
      oa = v.w ? v.a0 : v.a1;
      ol = v.w ? v.l0 : v.l1;
      push_burst(v.w, wa, wl, start, nxt, la);
      fin = nxt;
      if (two) push_burst(!v.w, oa, ol, nxt, fin, la);
      @(negedge clk);
      check("gnt_first", 32'({c1_gnt, c0_gnt}), v.w ? 32'd2 : 32'd1);
      if (v.w) c1_req = 1'b0;
      else     c0_req = 1'b0;
      if (!two) begin
         c0_req = 1'b0;
         c1_req = 1'b0;
      end
      @(negedge clk);
      check("gnt_pulse", 32'({c1_gnt, c0_gnt}), 32'd0);
      if (two) begin
         while (cyc < nxt + 1) @(negedge clk);
         check("gnt_second", 32'({c1_gnt, c0_gnt}), v.w ? 32'd1 : 32'd2);
         c0_req = 1'b0;
         c1_req = 1'b0;
      end
      while (cyc < fin) @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("addr_hold", mem_address, la);
      check("sb_empty", 32'(sbq.size()), 32'd0);
   endtask

   vec_t tbl[7];
   vec_t vs;
   int   st, nx;
   bit   c0_seen;
   logic [31:0] la;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{r0:1, r1:1, a0:32'h20, a1:32'h30, l0:8'd2, l1:8'd3, w:1'b0, keep:1'b1};
      tbl[1] = '{r0:1, r1:1, a0:32'h28, a1:32'h08, l0:8'd3, l1:8'd2, w:1'b0, keep:1'b0};
      tbl[2] = '{r0:1, r1:1, a0:32'h18, a1:32'h2C, l0:8'd2, l1:8'd2, w:RR,   keep:1'b1};
      tbl[3] = '{r0:1, r1:0, a0:32'h10, a1:32'h00, l0:8'd4, l1:8'd0, w:1'b0, keep:1'b0};
      tbl[4] = '{r0:0, r1:1, a0:32'h00, a1:32'(MS-2), l0:8'd0, l1:8'd4, w:1'b1, keep:1'b0};
      tbl[5] = '{r0:1, r1:0, a0:32'h05, a1:32'h00, l0:8'd0, l1:8'd0, w:1'b0, keep:1'b0};
      tbl[6] = '{r0:0, r1:1, a0:32'h00, a1:32'h03, l0:8'd0, l1:8'd255, w:1'b1, keep:1'b0};

      rst = 1'b0;
      c0_req = 1'b0; c0_addr = '0; c0_len = '0;
      c1_req = 1'b0; c1_addr = '0; c1_len = '0;
      repeat (2) @(negedge clk);
      check("rst_flags", 32'({c0_gnt, c0_rvalid, c0_done, c1_gnt, c1_rvalid, c1_done, busy}), 32'd0);
      check("rst_addr", mem_address, 32'd0);
      check("rst_rdata", c0_rdata | c1_rdata, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(tbl[i]);

      // c0 raises and withdraws its request while c1 owns the memory
      @(negedge clk);
      c1_req = 1'b1; c1_addr = 32'h12; c1_len = 8'd6;
      st = cyc;
      push_burst(1'b1, 32'h12, 8'd6, st, nx, la);
      c0_seen = 1'b0;
      @(negedge clk);
      check("wd_c1_gnt", 32'(c1_gnt), 32'd1);
      c1_req = 1'b0;
      c0_req = 1'b1; c0_addr = 32'h33; c0_len = 8'd2;
      repeat (3) @(negedge clk) c0_seen |= c0_gnt;
      c0_req = 1'b0;
      while (cyc < nx + 3) @(negedge clk) c0_seen |= c0_gnt;
      check("wd_no_c0_gnt", 32'(c0_seen), 32'd0);
      check("wd_busy", 32'(busy), 32'd0);
      check("wd_sb_empty", 32'(sbq.size()), 32'd0);

      // reset lands on the second word of an 8-word burst
      @(negedge clk);
      c0_req = 1'b1; c0_addr = 32'h20; c0_len = 8'd8;
      st = cyc;
      sbq.push_back('{cl: 1'b0, data: mfun(32'h20), last: 1'b0, cyc: st + 2});
      @(negedge clk);
      check("rb_gnt", 32'(c0_gnt), 32'd1);
      c0_req = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rb_pre_rvalid", 32'(c0_rvalid), 32'd1);
      rst = 1'b0;
      #1;
      check("rb_flags", 32'({c0_gnt, c0_rvalid, c0_done, c1_gnt, c1_rvalid, c1_done, busy}), 32'd0);
      check("rb_rdata", c0_rdata | c1_rdata, 32'd0);
      check("rb_addr", mem_address, 32'd0);
      check("rb_sb_empty", 32'(sbq.size()), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("rb_idle", 32'(busy), 32'd0);

      vs = '{r0:1, r1:0, a0:32'h3A, a1:32'h00, l0:8'd1, l1:8'd0, w:1'b0, keep:1'b0};
      run_vec(vs);
      repeat (3) @(negedge clk);
      check("final_sb_empty", 32'(sbq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
